// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD frame-capture block.
// Holds the FSM state codes, the default image geometry and the derived
// word count for one packed frame (two 8-bit pixels per 16-bit word).
package ccd_pkg;

    localparam int unsigned CCD_IMG_W = 28;
    localparam int unsigned CCD_IMG_H = 28;
    localparam int unsigned CCD_WORDS = CCD_IMG_W * CCD_IMG_H / 2;

    // FSM state codes
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARM      = 3'd1;
    localparam logic [2:0] ST_WAIT_SOF = 3'd2;
    localparam logic [2:0] ST_CAPTURE  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/ccd_capture_pix_packer.sv
// Packs two consecutive 8-bit pixels into one 16-bit DMEM word.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   pix_store    pixel accepted and inside the active line width
//   lane_hi      1 = odd column (upper byte), 0 = even column (lower byte)
//   pix          pixel value
//   data         16-bit holding register, drives DMEM write data
//   word_rdy     one-cycle pulse the cycle after an odd pixel completes a word
module ccd_capture_pix_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_store,
    input  logic        lane_hi,
    input  logic [7:0]  pix,
    output logic [15:0] data,
    output logic        word_rdy
);

    // Byte lane select into the holding register plus the word-ready pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            word_rdy <= 1'b0;
        end else begin
            word_rdy <= pix_store & lane_hi;
            if (pix_store) begin
                if (lane_hi) data[15:8] <= pix;
                else         data[7:0]  <= pix;
            end
        end
    end

endmodule

// File: rtl/ccd_capture.sv
// Camera front-end: captures one IMG_W x IMG_H 8-bit grayscale frame and
// writes it, two pixels per word, to DMEM port B starting at BASE_ADDR.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   ccd_en              CPU capture request (level)
//   ccd_done            capture finished, held until ccd_en drops
//   ccd_err             frame malformed, valid while ccd_done=1
//   cam_fval/cam_lval   frame / line valid from the sensor
//   cam_pix_valid       pixel strobe
//   cam_pix             pixel value
//   ccd_dmem_addr/data/wren  DMEM port B write interface
module ccd_capture
    import ccd_pkg::*;
#(
    parameter int unsigned IMG_W     = CCD_IMG_W,
    parameter int unsigned IMG_H     = CCD_IMG_H,
    parameter int unsigned BASE_ADDR = 32'h400,
    parameter int unsigned ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ccd_en,
    output logic              ccd_done,
    output logic              ccd_err,
    input  logic              cam_fval,
    input  logic              cam_lval,
    input  logic              cam_pix_valid,
    input  logic [7:0]        cam_pix,
    output logic [ADDR_W-1:0] ccd_dmem_addr,
    output logic [15:0]       ccd_dmem_data,
    output logic              ccd_dmem_wren
);

    localparam int unsigned WORDS = IMG_W * IMG_H / 2;
    // col saturates at IMG_W+1 so overlong lines are still detectable
    localparam int unsigned COL_W = $clog2(IMG_W + 2);
    localparam int unsigned ROW_W = $clog2(IMG_H + 1);
    localparam int unsigned IDX_W = $clog2(WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    // Frame must fit in the DMEM address space without wrapping
    if (BASE_ADDR + WORDS > (1 << ADDR_W)) begin : g_addr_chk
        $error("ccd_capture: frame does not fit in DMEM address space");
    end

    logic [2:0]       state, state_nxt;
    logic [COL_W-1:0] col, col_cnt;
    logic [ROW_W-1:0] row, row_cnt;
    logic [IDX_W-1:0] word_idx;
    logic             fval_q, lval_q;
    logic             lval_fall, fval_fall, fval_rise;
    logic             acc_c, store_c;
    logic             clr_c, err_set_c, line_end_c;

    assign lval_fall = lval_q & ~cam_lval;
    assign fval_fall = fval_q & ~cam_fval;
    assign fval_rise = ~fval_q & cam_fval;

    assign acc_c   = (state == ST_CAPTURE) & cam_fval & cam_lval & cam_pix_valid;
    assign store_c = acc_c & (col < COL_W'(IMG_W));
    // Current pixel is counted before any same-cycle line-length check
    assign col_cnt = col + COL_W'(acc_c & (col <= COL_W'(IMG_W)));
    assign row_cnt = row + ROW_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control decode
    always_comb begin
        state_nxt  = state;
        clr_c      = 1'b0;
        err_set_c  = 1'b0;
        line_end_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ccd_en) begin
                    state_nxt = ST_ARM;
                    clr_c     = 1'b1;
                end
            end
            ST_ARM: begin
                if (!ccd_en)        state_nxt = ST_IDLE;
                else if (!cam_fval) state_nxt = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (!ccd_en)        state_nxt = ST_IDLE;
                else if (fval_rise) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!ccd_en) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (lval_fall) begin
                        line_end_c = 1'b1;
                        if (col_cnt != COL_W'(IMG_W)) err_set_c = 1'b1;
                    end
                    // Final line end wins over a same-cycle frame end
                    if (lval_fall && (row_cnt == ROW_W'(IMG_H))) begin
                        state_nxt = ST_DONE;
                    end else if (fval_fall) begin
                        err_set_c = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!ccd_en) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Counters, edge history, address generation and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fval_q        <= 1'b0;
            lval_q        <= 1'b0;
            col           <= '0;
            row           <= '0;
            word_idx      <= '0;
            ccd_dmem_addr <= BASE;
            ccd_err       <= 1'b0;
            ccd_done      <= 1'b0;
        end else begin
            fval_q   <= cam_fval;
            lval_q   <= cam_lval;
            ccd_done <= (state_nxt == ST_DONE);
            if (clr_c) begin
                col      <= '0;
                row      <= '0;
                word_idx <= '0;
                ccd_err  <= 1'b0;
            end else begin
                if (line_end_c) begin
                    col <= '0;
                    row <= row_cnt;
                end else begin
                    col <= col_cnt;
                end
                // Address is presented together with the packer's write pulse
                if (store_c && col[0]) begin
                    ccd_dmem_addr <= BASE + ADDR_W'(word_idx);
                    word_idx      <= word_idx + IDX_W'(1);
                end
                if (err_set_c) ccd_err <= 1'b1;
            end
        end
    end

    ccd_capture_pix_packer u_pix_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_store (store_c),
        .lane_hi   (col[0]),
        .pix       (cam_pix),
        .data      (ccd_dmem_data),
        .word_rdy  (ccd_dmem_wren)
    );

endmodule

// File: tb/tb_ccd_capture.sv
// Self-checking bench for ccd_capture: table of frame scenarios plus
// hand-written sequences for pre-running frames, abort and mid-capture reset.
module tb_ccd_capture;

    localparam int unsigned W      = 28;
    localparam int unsigned H      = 28;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned BASE   = 32'h400;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ccd_en;
    logic              ccd_done;
    logic              ccd_err;
    logic              cam_fval;
    logic              cam_lval;
    logic              cam_pix_valid;
    logic [7:0]        cam_pix;
    logic [ADDR_W-1:0] ccd_dmem_addr;
    logic [15:0]       ccd_dmem_data;
    logic              ccd_dmem_wren;

    ccd_capture #(
        .IMG_W     (W),
        .IMG_H     (H),
        .BASE_ADDR (BASE),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ccd_en        (ccd_en),
        .ccd_done      (ccd_done),
        .ccd_err       (ccd_err),
        .cam_fval      (cam_fval),
        .cam_lval      (cam_lval),
        .cam_pix_valid (cam_pix_valid),
        .cam_pix       (cam_pix),
        .ccd_dmem_addr (ccd_dmem_addr),
        .ccd_dmem_data (ccd_dmem_data),
        .ccd_dmem_wren (ccd_dmem_wren)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [ADDR_W-1:0] obs_addr[$];
    logic [15:0]       obs_data[$];
    logic [15:0]       exp_data[$];

    // Write monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ccd_dmem_wren === 1'b1) begin
            obs_addr.push_back(ccd_dmem_addr);
            obs_data.push_back(ccd_dmem_data);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int lines;
        int ppl;
        int gap;        // 0 none, 1 every 3rd cycle low, 2 random
        bit rnd;
        int exp_writes;
        bit exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        obs_addr.delete();
        obs_data.delete();
        exp_data.delete();
    endtask

    // Drives one camera frame; when cap is set, the reference model records
    // every word the capture should produce: the two pixels of each in-width
    // pair of the first H lines, in arrival order.
    task automatic send_frame(input int lines, input int ppl, input int gap,
                              input bit rnd, input bit cap_in, input int abort_line);
        bit         cap;
        bit         v;
        int         c;
        logic [7:0] lo;
        logic [7:0] p;
        cap = cap_in;
        lo  = 8'h00;
        cam_fval = 1'b1;
        tick();
        tick();
        for (int r = 0; r < lines; r++) begin
            c = 0;
            cam_lval = 1'b1;
            while (c < ppl) begin
                if (r == abort_line && c == 14 && ccd_en) begin
                    cam_pix_valid = 1'b0;
                    ccd_en = 1'b0;
                    tick();
                    cap = 1'b0;
                end
                case (gap)
                    0:       v = 1'b1;
                    1:       v = (cyc % 3) != 2;
                    default: v = 1'($urandom_range(0, 1));
                endcase
                cam_pix_valid = v;
                if (v) begin
                    p = rnd ? 8'($urandom) : 8'(r * W + c);
                    cam_pix = p;
                    if (cap && r < H && c < W) begin
                        if (c % 2 == 0) lo = p;
                        else            exp_data.push_back({p, lo});
                    end
                    c++;
                end
                tick();
            end
            cam_lval = 1'b0;
            cam_pix_valid = 1'b0;
            tick();
            tick();
        end
        cam_fval = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic finish_check(input string name, input int exp_writes, input bit exp_err);
        int mism;
        for (int i = 0; i < 500 && ccd_done !== 1'b1; i++) tick();
        check({name, "_done"}, 32'(ccd_done), 1);
        check({name, "_err"}, 32'(ccd_err), 32'(exp_err));
        check({name, "_writes"}, obs_data.size(), exp_writes);
        check({name, "_model_cnt"}, obs_data.size(), exp_data.size());
        mism = 0;
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++)
            if (obs_addr[i] !== ADDR_W'(BASE + i) || obs_data[i] !== exp_data[i]) mism++;
        check({name, "_content"}, mism, 0);
        ccd_en = 1'b0;
        tick();
        check({name, "_done_clr"}, 32'(ccd_done), 0);
    endtask

    task automatic run_vec(input int idx);
        ccd_en = 1'b1;
        tick();
        tick();
        tick();
        clear_q();
        send_frame(vecs[idx].lines, vecs[idx].ppl, vecs[idx].gap, vecs[idx].rnd, 1'b1, -1);
        finish_check($sformatf("v%0d", idx), vecs[idx].exp_writes, vecs[idx].exp_err);
    endtask

    initial begin
        vecs[0] = '{lines: 28, ppl: 28, gap: 0, rnd: 1'b0, exp_writes: 392, exp_err: 1'b0};
        vecs[1] = '{lines: 30, ppl: 32, gap: 1, rnd: 1'b0, exp_writes: 392, exp_err: 1'b1};
        vecs[2] = '{lines: 10, ppl: 28, gap: 0, rnd: 1'b0, exp_writes: 140, exp_err: 1'b1};
        vecs[3] = '{lines: 28, ppl: 28, gap: 2, rnd: 1'b1, exp_writes: 392, exp_err: 1'b0};
        vecs[4] = '{lines: 28, ppl: 26, gap: 2, rnd: 1'b1, exp_writes: 364, exp_err: 1'b1};
        vecs[5] = '{lines: 28, ppl: 27, gap: 0, rnd: 1'b1, exp_writes: 364, exp_err: 1'b1};

        rst_n = 1'b0;
        ccd_en = 1'b0;
        cam_fval = 1'b0;
        cam_lval = 1'b0;
        cam_pix_valid = 1'b0;
        cam_pix = 8'h00;
        tick();
        tick();
        check("rst_done", 32'(ccd_done), 0);
        check("rst_err", 32'(ccd_err), 0);
        check("rst_wren", 32'(ccd_dmem_wren), 0);
        check("rst_addr", 32'(ccd_dmem_addr), 32'h400);
        check("rst_data", 32'(ccd_dmem_data), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            run_vec(i);
            if (i == 0) begin
                check("t1_word0", obs_data.size() > 0 ? 32'(obs_data[0]) : 32'hdead, 32'h0100);
                check("t1_word1", obs_data.size() > 1 ? 32'(obs_data[1]) : 32'hdead, 32'h0302);
                check("t1_last_addr", obs_addr.size() == 392 ? 32'(obs_addr[391]) : 32'hdead, 32'h587);
            end
        end

        // Frame already running when capture is requested
        cam_fval = 1'b1;
        tick();
        ccd_en = 1'b1;
        clear_q();
        send_frame(28, 28, 0, 1'b1, 1'b0, -1);
        check("pre_nowrites", obs_data.size(), 0);
        check("pre_notdone", 32'(ccd_done), 0);
        clear_q();
        send_frame(28, 28, 0, 1'b0, 1'b1, -1);
        finish_check("pre", 392, 1'b0);

        // Abort mid-line 5, then a clean recapture
        ccd_en = 1'b1;
        tick();
        tick();
        tick();
        clear_q();
        send_frame(28, 28, 0, 1'b1, 1'b1, 5);
        check("abort_writes", obs_data.size(), 77);
        check("abort_model_cnt", obs_data.size(), exp_data.size());
        check("abort_last", obs_data.size() == 77 ? 32'(obs_data[76]) : 32'hdead,
              exp_data.size() == 77 ? 32'(exp_data[76]) : 32'hbeef);
        check("abort_notdone", 32'(ccd_done), 0);
        run_vec(0);

        // Reset while an odd pixel's write is pending
        ccd_en = 1'b1;
        tick();
        tick();
        tick();
        clear_q();
        cam_fval = 1'b1;
        tick();
        tick();
        cam_lval = 1'b1;
        cam_pix_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cam_pix = 8'(c + 8'h40);
            tick();
        end
        cam_pix = 8'h45;
        #2;
        rst_n = 1'b0;
        ccd_en = 1'b0;
        cam_fval = 1'b0;
        cam_lval = 1'b0;
        cam_pix_valid = 1'b0;
        #1;
        check("mrst_wren", 32'(ccd_dmem_wren), 0);
        check("mrst_addr", 32'(ccd_dmem_addr), 32'h400);
        check("mrst_data", 32'(ccd_dmem_data), 0);
        check("mrst_done", 32'(ccd_done), 0);
        check("mrst_err", 32'(ccd_err), 0);
        tick();
        check("mrst_wren_after", 32'(ccd_dmem_wren), 0);
        check("mrst_prior_writes", obs_data.size(), 2);
        rst_n = 1'b1;
        tick();
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
